// File: rtl/sysid_read_arbiter_if.sv
// Bus bundle between two Avalon-MM read masters, the arbiter and one shared read-only slave.
// The arbiter uses the "slave" modport; the "master" modport is the requester/slave-model side.
interface sysid_read_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 1
);
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_readdata;

    modport slave (
        input  m0_address, m0_read, m1_address, m1_read, s_readdata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
               m1_waitrequest, m1_readdata, m1_readdatavalid, s_address
    );

    modport master (
        output m0_address, m0_read, m1_address, m1_read, s_readdata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
               m1_waitrequest, m1_readdata, m1_readdatavalid, s_address
    );
endinterface

// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency read-only slave between two read masters.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT*L -> RESP -> IDLE.
module sysid_read_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 1,
    parameter int SLAVE_LATENCY = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    sysid_read_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [1:0] LAT = SLAVE_LATENCY[1:0];

    state_e            state_q;
    logic              last_grant_q;
    logic              grant_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rvalid_q;

    logic idle, win0, win1;

    // On contention the master that did not win last time gets the slot.
    assign idle = (state_q == IDLE);
    assign win0 = bus.m0_read && (!bus.m1_read || last_grant_q);
    assign win1 = bus.m1_read && (!bus.m0_read || !last_grant_q);

    assign bus.m0_waitrequest   = !(reset_n_i && idle && win0);
    assign bus.m1_waitrequest   = !(reset_n_i && idle && win1);
    assign bus.m0_readdata      = rdata_q;
    assign bus.m1_readdata      = rdata_q;
    assign bus.m0_readdatavalid = rvalid_q[0];
    assign bus.m1_readdatavalid = rvalid_q[1];
    assign bus.s_address        = s_addr_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= 2'd0;
            s_addr_q     <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win0 || win1) begin
                        s_addr_q     <= win0 ? bus.m0_address : bus.m1_address;
                        grant_q      <= win1;
                        last_grant_q <= win1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (SLAVE_LATENCY == 0) begin
                        rdata_q  <= bus.s_readdata;
                        rvalid_q <= grant_q ? 2'b10 : 2'b01;
                        state_q  <= RESP;
                    end else begin
                        cnt_q   <= 2'd1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Data is sampled on the last of the SLAVE_LATENCY wait cycles.
                    if (cnt_q == LAT) begin
                        rdata_q  <= bus.s_readdata;
                        rvalid_q <= grant_q ? 2'b10 : 2'b01;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    rvalid_q <= 2'b00;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed bench: a per-cycle vector table on a zero-latency instance, plus hand
// sequences for reset-abort and a latency-2 instance.
module tb_sysid_read_arbiter;
    localparam logic [31:0] D = 32'h603DB1C6;

    logic clock = 1'b0;
    logic rst0_n, rst2_n;
    always #5 clock = ~clock;

    sysid_read_arbiter_if #(.DATA_W(32), .ADDR_W(1)) b0 ();
    sysid_read_arbiter_if #(.DATA_W(32), .ADDR_W(1)) b2 ();

    sysid_read_arbiter #(.DATA_W(32), .ADDR_W(1), .SLAVE_LATENCY(0)) dut0 (
        .clock_i(clock), .reset_n_i(rst0_n), .bus(b0.slave));
    sysid_read_arbiter #(.DATA_W(32), .ADDR_W(1), .SLAVE_LATENCY(2)) dut2 (
        .clock_i(clock), .reset_n_i(rst2_n), .bus(b2.slave));

    // Slave models: addr0 -> 0, addr1 -> D, delayed by the instance latency.
    logic d1 = 1'b0, d2 = 1'b0;
    always @(posedge clock) begin
        d1 <= b2.s_address[0];
        d2 <= d1;
    end
    assign b0.s_readdata = b0.s_address[0] ? D : 32'h0;
    assign b2.s_readdata = d2 ? D : 32'h0;

    typedef struct {
        logic rst, r0, a0, r1, a1;
        logic w0, w1, v0, v1, sa;
        logic [31:0] rd;
    } vec_t;
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, r0, a0, r1, a1, w0, w1, v0, v1, sa,
                       input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.w0 = w0; v.w1 = w1; v.v0 = v0; v.v1 = v1; v.sa = sa; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic drv0(input logic r0, a0, r1, a1);
        b0.m0_read = r0; b0.m0_address = a0; b0.m1_read = r1; b0.m1_address = a1;
    endtask

    task automatic chk0(input string p, input logic w0, w1, v0, v1, sa, input logic [31:0] rd);
        chk({p, " m0_waitrequest"},   32'(b0.m0_waitrequest),   32'(w0));
        chk({p, " m1_waitrequest"},   32'(b0.m1_waitrequest),   32'(w1));
        chk({p, " m0_readdatavalid"}, 32'(b0.m0_readdatavalid), 32'(v0));
        chk({p, " m1_readdatavalid"}, 32'(b0.m1_readdatavalid), 32'(v1));
        chk({p, " s_address"},        32'(b0.s_address),        32'(sa));
        chk({p, " m0_readdata"},      b0.m0_readdata,           rd);
        chk({p, " m1_readdata"},      b0.m1_readdata,           rd);
    endtask

    task automatic chk2(input string p, input logic w0, w1, v0, v1, input logic [31:0] rd);
        chk({p, " m0_waitrequest"},   32'(b2.m0_waitrequest),   32'(w0));
        chk({p, " m1_waitrequest"},   32'(b2.m1_waitrequest),   32'(w1));
        chk({p, " m0_readdatavalid"}, 32'(b2.m0_readdatavalid), 32'(v0));
        chk({p, " m1_readdatavalid"}, 32'(b2.m1_readdatavalid), 32'(v1));
        chk({p, " readdata"},         b2.m1_readdata,           rd);
    endtask

    initial begin
        rst0_n = 1'b0; rst2_n = 1'b0;
        drv0(0, 0, 0, 0);
        b2.m0_read = 0; b2.m0_address = 0; b2.m1_read = 0; b2.m1_address = 0;

        //   rst r0 a0 r1 a1   w0 w1 v0 v1 sa  rd
        // held in reset while masters toggle
        add(0, 1, 1, 1, 1,   1, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0);
        // m0 alone reads addr1
        add(1, 1, 1, 0, 0,   0, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 0, 1, 32'h0);
        add(1, 0, 0, 0, 0,   1, 1, 1, 0, 1, D);
        add(1, 0, 0, 0, 0,   1, 1, 0, 0, 1, D);
        // reset clears data/address and restores last_grant=1
        add(0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0);
        // both request: m0 (addr1) first, m1 (addr0) stalled then served
        add(1, 1, 1, 1, 0,   0, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 1, 0,   1, 1, 0, 0, 1, 32'h0);
        add(1, 0, 0, 1, 0,   1, 1, 1, 0, 1, D);
        add(1, 0, 0, 1, 0,   1, 0, 0, 0, 1, D);
        add(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, D);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 32'h0);
        // continuous contention: grants 0,1,0,1 every 3 cycles
        add(1, 1, 1, 1, 0,   0, 1, 0, 0, 0, 32'h0);
        add(1, 1, 1, 1, 0,   1, 1, 0, 0, 1, 32'h0);
        add(1, 1, 1, 1, 0,   1, 1, 1, 0, 1, D);
        add(1, 1, 1, 1, 0,   1, 0, 0, 0, 1, D);
        add(1, 1, 1, 1, 0,   1, 1, 0, 0, 0, D);
        add(1, 1, 1, 1, 0,   1, 1, 0, 1, 0, 32'h0);
        add(1, 1, 1, 1, 0,   0, 1, 0, 0, 0, 32'h0);
        add(1, 1, 1, 1, 0,   1, 1, 0, 0, 1, 32'h0);
        add(1, 1, 1, 1, 0,   1, 1, 1, 0, 1, D);
        add(1, 1, 1, 1, 0,   1, 0, 0, 0, 1, D);
        add(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, D);
        add(1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 32'h0);

        foreach (vecs[i]) begin
            @(posedge clock); #1;
            rst0_n = vecs[i].rst;
            drv0(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
            @(negedge clock);
            chk0($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].v0,
                 vecs[i].v1, vecs[i].sa, vecs[i].rd);
        end

        // Reset in the middle of an m0 transaction: no response may ever appear.
        @(posedge clock); #1; drv0(1, 1, 0, 0);
        @(negedge clock); chk0("abort T", 0, 1, 0, 0, 0, 32'h0);
        @(posedge clock); #1; drv0(0, 0, 0, 0); rst0_n = 1'b0;
        @(negedge clock); chk0("abort T+1", 1, 1, 0, 0, 0, 32'h0);
        @(posedge clock); #1;
        @(negedge clock); chk0("abort T+2", 1, 1, 0, 0, 0, 32'h0);
        @(posedge clock); #1; rst0_n = 1'b1; drv0(0, 0, 1, 1);
        @(negedge clock); chk0("abort T+3", 1, 0, 0, 0, 0, 32'h0);
        @(posedge clock); #1; drv0(0, 0, 0, 0);
        @(negedge clock); chk0("abort T+4", 1, 1, 0, 0, 1, 32'h0);
        @(posedge clock); #1;
        @(negedge clock); chk0("abort T+5", 1, 1, 0, 1, 1, D);
        @(posedge clock); #1;
        @(negedge clock); chk0("abort T+6", 1, 1, 0, 0, 1, D);

        // Latency-2 instance: m1 reads addr1, m0 stalled throughout.
        @(posedge clock); #1; rst2_n = 1'b1;
        @(posedge clock); #1; b2.m1_read = 1; b2.m1_address = 1;
        @(negedge clock); chk2("lat2 T", 1, 0, 0, 0, 32'h0);
        @(posedge clock); #1; b2.m1_read = 0; b2.m0_read = 1; b2.m0_address = 0;
        @(negedge clock); chk2("lat2 T+1", 1, 1, 0, 0, 32'h0);
        @(posedge clock); #1;
        @(negedge clock); chk2("lat2 T+2", 1, 1, 0, 0, 32'h0);
        @(posedge clock); #1;
        @(negedge clock); chk2("lat2 T+3", 1, 1, 0, 0, 32'h0);
        @(posedge clock); #1;
        @(negedge clock); chk2("lat2 T+4", 1, 1, 0, 1, D);
        @(posedge clock); #1;
        @(negedge clock); chk2("lat2 T+5", 0, 1, 0, 0, D);
        @(posedge clock); #1; b2.m0_read = 0;
        repeat (6) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
